kbd_decoder: RTL and testbench
==============================

# kbd_decoder

Consumes the byte stream popped from the `ps2_keyboard` receive FIFO and turns raw PS/2 set-2 scan codes into key state. It decodes make, break (`F0`) and extended (`E0`) prefixes, tracks the currently held key, counts distinct key presses and converts the held key to ASCII. It drives six 7-segment digits on the board. It sits between `ps2_keyboard` and the top-level `seg0`..`seg5` outputs, replacing the free-running `seg` demo for those digits.

## Interface

Parameters:
- `SEG_INV`, default 1: 1 = segment outputs are active-low (inverted pattern); 0 = active-high.

Ports:
- `clk` in 1: system clock, same clock as `ps2_keyboard`.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_data` in 8: FIFO head byte from `ps2_keyboard`; valid while `ps2_ready`=1.
- `ps2_ready` in 1: FIFO non-empty.
- `ps2_overflow` in 1: FIFO overflow indication from `ps2_keyboard`.
- `nextdata_n` out 1: active-low pop strobe to `ps2_keyboard`.
- `key_down` out 1: a key is currently held.
- `scan_code` out 8: make code of the held key; 0 when none is held.
- `ext_key` out 1: the held key was `E0`-prefixed.
- `ascii` out 8: ASCII of the held key; 0 if unmapped, extended, or no key held.
- `key_cnt` out 8: count of new key presses, modulo 256.
- `ovf_seen` out 1: sticky; `ps2_overflow` was seen high.
- `seg0`..`seg5` out 8 each: digit patterns. Bits [7:1] = segments a..g, bit [0] = dp.

## Operation

Pop FSM has three states: IDLE, POP, WAIT.
- IDLE with `ps2_ready`=1: latch `ps2_data` into `code_r`, go to POP.
- POP: `nextdata_n`=0, decoded combinationally from state. Process `code_r` at the end of the cycle, then go to WAIT.
- WAIT: ignore `ps2_ready` for one cycle so the FIFO read pointer settles, then go to IDLE.
- `nextdata_n`=1 in every state except POP.

Byte processing in POP:
- `E0`: set `ext_f`.
- `F0`: set `brk_f`.
- Any other byte with `brk_f`=1 is a release:
  - If the byte equals `scan_code` and `ext_f` equals `ext_key`, clear `key_down`, `scan_code` and `ext_key`.
  - Otherwise the held state is unchanged.
  - In both cases clear `brk_f` and `ext_f`.
- Any other byte with `brk_f`=0 is a make:
  - If `key_down`=1 and the byte and `ext_f` match the held key, it is typematic repeat: no change.
  - Otherwise set `key_down`=1, `scan_code`=byte, `ext_key`=`ext_f`, and `key_cnt` +1 (255 wraps to 0).
  - In both cases clear `ext_f`.
- `E0` followed by `F0` is a legal extended break; both flags are held until the final byte.

Overflow:
- `ps2_overflow` is sampled every cycle; `ovf_seen` sets on the first high sample and clears only on reset.

Display:
- `seg1`/`seg0` = `scan_code` high/low nibble.
- `seg3`/`seg2` = `ascii` high/low nibble.
- `seg5`/`seg4` = `key_cnt` high/low nibble.
- `seg0`..`seg3` are blank while `key_down`=0.
- `seg4`/`seg5` are always shown, including 00.
- dp of `seg0` is lit while `ovf_seen`=1; all other dp bits are off.

## Timing

- Reset values:
  - FSM = IDLE; `nextdata_n`=1.
  - `key_down`=0, `scan_code`=0, `ext_key`=0, `ascii`=0, `key_cnt`=0, `ovf_seen`=0; `ext_f`=`brk_f`=0.
  - `seg0`..`seg3` blank; `seg4`/`seg5` show 0.
  - Blank = 8'hFF when `SEG_INV`=1, 8'h00 when `SEG_INV`=0.
- Latency: with `ps2_ready` sampled high in cycle T, `nextdata_n` is low in T+1 only, and the updated key state and segments are visible in T+2.
- Throughput: at most one byte per 3 cycles; back-to-back FIFO bytes are never double-popped.
- `ascii` and the segment outputs are combinational from registered state; there is no extra latency.
- Reset asserted mid-sequence (e.g. after `F0`) discards the partial prefix. The next byte after release is treated as a fresh code.
- `ps2_ready` dropping during POP or WAIT has no effect; the pop already issued stands.

## Configuration

- `KBD_DECODER_SHIFT_EN` defined:
  - Track left shift (`12`) and right shift (`59`) make/break independently. Shift keys do not become the held key and do not count.
  - `ascii` returns uppercase letters and shifted symbols while either shift is down.
- `KBD_DECODER_SHIFT_EN` undefined:
  - `12`/`59` are ordinary keys (held and counted, `ascii`=0).
  - `ascii` is lowercase/unshifted only.

## Structure

- Package `kbd_pkg` holds:
  - Constants `KBD_EXT`=8'hE0, `KBD_BRK`=8'hF0, `KBD_LSHIFT`, `KBD_RSHIFT`.
  - The FSM state enum.
  - The 16-entry hex-to-segment table: '0'=7'b1111110 for a..g, active-high, before `SEG_INV`.
  - Blank constant and digit function.
- One sub-module `kbd_scan2ascii`: combinational LUT, scan code + shift → ASCII. It covers letters, digits, space (`29`→8'h20) and enter (`5A`→8'h0D).

## Test plan

- Reset release, FIFO empty → `nextdata_n` stays 1, `key_cnt`=0, `seg0`..`seg3` = 8'hFF.
- Bytes `1C`, `F0`, `1C` → after `1C`: `key_down`=1, `scan_code`=8'h1C, `ascii`=8'h61, `key_cnt`=1; after `F0 1C`: `key_down`=0, segments blank.
- Bytes `1C` ×5 (typematic), then `F0 1C` → `key_cnt`=1; exactly 7 single-cycle `nextdata_n` pulses, each ≥3 cycles apart.
- Bytes `E0 75`, then `E0 F0 75` → `ext_key`=1, `scan_code`=8'h75, `ascii`=0; released after the second sequence. A non-extended `F0 75` does not release it.
- 256 distinct press/release pairs → `key_cnt` wraps to 0; `seg5`/`seg4` show 00.
- `ps2_overflow` pulsed for 1 cycle → `ovf_seen`=1 and `seg0` dp lit until `resetn` is asserted. With `KBD_DECODER_SHIFT_EN`: `12 1C` → `ascii`=8'h41, `key_cnt`=1.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_decoder shared constants: scan-code prefixes, pop FSM states,
// and the hex-to-7-segment table with its digit encoder.
package kbd_pkg;

  localparam logic [7:0] KBD_EXT    = 8'hE0;
  localparam logic [7:0] KBD_BRK    = 8'hF0;
  localparam logic [7:0] KBD_LSHIFT = 8'h12;
  localparam logic [7:0] KBD_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT
  } pop_state_t;

  // a..g active-high, entry 15 first
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg_digit(
    input logic [3:0] nib,
    input logic       show,
    input logic       dp,
    input logic       inv
  );
    logic [7:0] p;
    p = show ? {SEG_HEX[nib], dp} : (SEG_BLANK | {7'b0, dp});
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Set-2 scan code to ASCII lookup: letters, digits, space, enter.
// The shift input selects uppercase / shifted symbols.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (code)
      8'h1C: pair = {"a", "A"};
      8'h32: pair = {"b", "B"};
      8'h21: pair = {"c", "C"};
      8'h23: pair = {"d", "D"};
      8'h24: pair = {"e", "E"};
      8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};
      8'h33: pair = {"h", "H"};
      8'h43: pair = {"i", "I"};
      8'h3B: pair = {"j", "J"};
      8'h42: pair = {"k", "K"};
      8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};
      8'h31: pair = {"n", "N"};
      8'h44: pair = {"o", "O"};
      8'h4D: pair = {"p", "P"};
      8'h15: pair = {"q", "Q"};
      8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};
      8'h2C: pair = {"t", "T"};
      8'h3C: pair = {"u", "U"};
      8'h2A: pair = {"v", "V"};
      8'h1D: pair = {"w", "W"};
      8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};
      8'h1A: pair = {"z", "Z"};
      8'h16: pair = {"1", "!"};
      8'h1E: pair = {"2", "@"};
      8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};
      8'h2E: pair = {"5", "%"};
      8'h36: pair = {"6", "^"};
      8'h3D: pair = {"7", "&"};
      8'h3E: pair = {"8", "*"};
      8'h46: pair = {"9", "("};
      8'h45: pair = {"0", ")"};
      8'h29: pair = {8'h20, 8'h20};
      8'h5A: pair = {8'h0D, 8'h0D};
      default: pair = 16'h0000;
    endcase
  end

  assign ascii = shift ? pair[7:0] : pair[15:8];

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 set-2 key decoder: pops FIFO bytes, tracks held key, counts presses,
// drives six 7-seg digits. Define KBD_DECODER_SHIFT_EN for shift tracking.
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int SEG_INV = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       nextdata_n,
  output logic       key_down,
  output logic [7:0] scan_code,
  output logic       ext_key,
  output logic [7:0] ascii,
  output logic [7:0] key_cnt,
  output logic       ovf_seen,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5
);

  localparam logic INV = (SEG_INV != 0);

  pop_state_t state, state_nx;
  logic [7:0] code_r;
  logic       ext_f, brk_f;
  logic       is_shift, shift_dn;
  logic       held_match, rel_match;
  logic [7:0] lut_ascii;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (ps2_ready) state_nx = ST_POP;
      ST_POP:  state_nx = ST_WAIT;
      ST_WAIT: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    nextdata_n = (state != ST_POP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          code_r <= 8'h00;
    else if (state == ST_IDLE && ps2_ready) code_r <= ps2_data;
  end

`ifdef KBD_DECODER_SHIFT_EN
  logic lshift_r, rshift_r;

  assign is_shift = (code_r == KBD_LSHIFT) || (code_r == KBD_RSHIFT);
  assign shift_dn = lshift_r | rshift_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lshift_r <= 1'b0;
      rshift_r <= 1'b0;
    end else if (state == ST_POP) begin
      if (code_r == KBD_LSHIFT) lshift_r <= !brk_f;
      if (code_r == KBD_RSHIFT) rshift_r <= !brk_f;
    end
  end
`else
  assign is_shift = 1'b0;
  assign shift_dn = 1'b0;
`endif

  assign rel_match  = (code_r == scan_code) && (ext_f == ext_key);
  assign held_match = key_down && rel_match;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_down  <= 1'b0;
      scan_code <= 8'h00;
      ext_key   <= 1'b0;
      key_cnt   <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      ovf_seen  <= 1'b0;
    end else begin
      if (ps2_overflow) ovf_seen <= 1'b1;
      if (state == ST_POP) begin
        if (code_r == KBD_EXT) begin
          ext_f <= 1'b1;
        end else if (code_r == KBD_BRK) begin
          brk_f <= 1'b1;
        end else if (is_shift) begin
          brk_f <= 1'b0;
          ext_f <= 1'b0;
        end else if (brk_f) begin
          if (rel_match) begin
            key_down  <= 1'b0;
            scan_code <= 8'h00;
            ext_key   <= 1'b0;
          end
          brk_f <= 1'b0;
          ext_f <= 1'b0;
        end else begin
          // a repeat of the held key is typematic, not a new press
          if (!held_match) begin
            key_down  <= 1'b1;
            scan_code <= code_r;
            ext_key   <= ext_f;
            key_cnt   <= key_cnt + 8'd1;
          end
          ext_f <= 1'b0;
        end
      end
    end
  end

  kbd_scan2ascii u_lut (
    .code  (scan_code),
    .shift (shift_dn),
    .ascii (lut_ascii)
  );

  assign ascii = (key_down && !ext_key) ? lut_ascii : 8'h00;

  assign seg0 = seg_digit(scan_code[3:0], key_down, ovf_seen, INV);
  assign seg1 = seg_digit(scan_code[7:4], key_down, 1'b0, INV);
  assign seg2 = seg_digit(ascii[3:0], key_down, 1'b0, INV);
  assign seg3 = seg_digit(ascii[7:4], key_down, 1'b0, INV);
  assign seg4 = seg_digit(key_cnt[3:0], 1'b1, 1'b0, INV);
  assign seg5 = seg_digit(key_cnt[7:4], 1'b1, 1'b0, INV);

endmodule

// File: tb/tb_kbd_decoder.sv
// Directed scoreboard bench for kbd_decoder with a FIFO-like byte source
// and a reference key-state model.
module tb_kbd_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       nextdata_n, key_down, ext_key, ovf_seen;
  logic [7:0] scan_code, ascii, key_cnt;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_decoder #(.SEG_INV(1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .key_down     (key_down),
    .scan_code    (scan_code),
    .ext_key      (ext_key),
    .ascii        (ascii),
    .key_cnt      (key_cnt),
    .ovf_seen     (ovf_seen),
    .seg0         (seg0),
    .seg1         (seg1),
    .seg2         (seg2),
    .seg3         (seg3),
    .seg4         (seg4),
    .seg5         (seg5)
  );

  typedef struct packed {
    logic       kd;
    logic [7:0] sc;
    logic       ek;
    logic [7:0] asc;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo[$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int pulses = 0;
  int last_pulse = -100;

  logic       m_down, m_ext, m_extf, m_brkf, m_lsh, m_rsh;
  logic [7:0] m_code, m_cnt;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_ascii(input logic [7:0] c,
                                         input logic sh);
    case (c)
      8'h1C:   return sh ? 8'h41 : 8'h61;
      8'h32:   return sh ? 8'h42 : 8'h62;
      8'h21:   return sh ? 8'h43 : 8'h63;
      8'h23:   return sh ? 8'h44 : 8'h64;
      8'h16:   return sh ? 8'h21 : 8'h31;
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_down = 0; m_ext = 0; m_extf = 0; m_brkf = 0;
    m_lsh = 0; m_rsh = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic push(input logic [7:0] b);
    exp_t e;
    logic same;
    same = m_down && (b == m_code) && (m_extf == m_ext);
    if (b == 8'hE0) m_extf = 1;
    else if (b == 8'hF0) m_brkf = 1;
`ifdef KBD_DECODER_SHIFT_EN
    else if (b == 8'h12 || b == 8'h59) begin
      if (b == 8'h12) m_lsh = !m_brkf;
      else            m_rsh = !m_brkf;
      m_brkf = 0; m_extf = 0;
    end
`endif
    else if (m_brkf) begin
      if (same) begin m_down = 0; m_code = 0; m_ext = 0; end
      m_brkf = 0; m_extf = 0;
    end else begin
      if (!same) begin
        m_down = 1; m_code = b; m_ext = m_extf; m_cnt = m_cnt + 8'd1;
      end
      m_extf = 0;
    end
    e.kd  = m_down;
    e.sc  = m_code;
    e.ek  = m_ext;
    e.cnt = m_cnt;
    e.asc = (m_down && !m_ext) ? m_ascii(m_code, m_lsh | m_rsh) : 8'h00;
    sb.push_back(e);
    fifo.push_back(b);
  endtask

  task automatic run();
    int   n;
    int   budget;
    logic pend;
    exp_t e;
    n = 0;
    pend = 0;
    budget = fifo.size() * 5 + 10;
    while ((fifo.size() > 0 || pend) && n < budget) begin
      ps2_ready = (fifo.size() > 0);
      ps2_data  = ps2_ready ? fifo[0] : 8'h00;
      @(negedge clk);
      n++;
      if (pend) begin
        e = sb.pop_front();
        pend = 0;
        chk("pulse_w", 8'(nextdata_n), 8'h01);
        chk("key_down", 8'(key_down), 8'(e.kd));
        chk("scan_code", scan_code, e.sc);
        chk("ext_key", 8'(ext_key), 8'(e.ek));
        chk("ascii", ascii, e.asc);
        chk("key_cnt", key_cnt, e.cnt);
      end
      if (!nextdata_n) begin
        chk("pop_gap", 8'(cyc - last_pulse >= 3), 8'h01);
        last_pulse = cyc;
        pulses++;
        void'(fifo.pop_front());
        pend = 1;
      end
    end
    ps2_ready = 0;
    ps2_data  = 8'h00;
    if (n >= budget) begin
      chk("timeout", 8'(fifo.size()), 8'h00);
      fifo.delete();
      sb.delete();
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    ps2_ready = 0;
    fifo.delete();
    sb.delete();
    m_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    pulses = 0;
    repeat (8) @(negedge clk);
    chk("idle_pulses", 8'(pulses), 8'h00);
    chk("idle_nextdata", 8'(nextdata_n), 8'h01);
    chk("rst_cnt", key_cnt, 8'h00);
    chk("rst_kd", 8'(key_down), 8'h00);
    chk("rst_ovf", 8'(ovf_seen), 8'h00);
    chk("rst_seg0", seg0, 8'hFF);
    chk("rst_seg1", seg1, 8'hFF);
    chk("rst_seg2", seg2, 8'hFF);
    chk("rst_seg3", seg3, 8'hFF);
    chk("rst_seg4", seg4, 8'h03);
    chk("rst_seg5", seg5, 8'h03);

    // single press of 'a'
    push(8'h1C);
    run();
    chk("a_sc", scan_code, 8'h1C);
    chk("a_ascii", ascii, 8'h61);
    chk("a_cnt", key_cnt, 8'h01);
    chk("a_seg0", seg0, 8'h63);
    chk("a_seg1", seg1, 8'h9F);
    chk("a_seg2", seg2, 8'h9F);
    chk("a_seg3", seg3, 8'h41);
    chk("a_seg4", seg4, 8'h9F);
    chk("a_seg5", seg5, 8'h03);
    push(8'hF0);
    push(8'h1C);
    run();
    chk("a_rel_kd", 8'(key_down), 8'h00);
    chk("a_rel_seg0", seg0, 8'hFF);
    chk("a_rel_seg3", seg3, 8'hFF);

    // typematic burst, all bytes queued back-to-back
    do_reset();
    pulses = 0;
    repeat (5) push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    run();
    chk("typ_pulses", 8'(pulses), 8'h07);
    chk("typ_cnt", key_cnt, 8'h01);
    chk("typ_kd", 8'(key_down), 8'h00);

    // extended keys
    do_reset();
    push(8'hE0);
    push(8'h75);
    run();
    chk("ext_ek", 8'(ext_key), 8'h01);
    chk("ext_sc", scan_code, 8'h75);
    chk("ext_ascii", ascii, 8'h00);
    push(8'hF0);
    push(8'h75);
    run();
    chk("ext_nonext_kd", 8'(key_down), 8'h01);
    push(8'hE0);
    push(8'hF0);
    push(8'h75);
    run();
    chk("ext_rel_kd", 8'(key_down), 8'h00);
    chk("ext_rel_sc", scan_code, 8'h00);
    push(8'hE0);
    push(8'h1C);
    run();
    chk("ext_a_ascii", ascii, 8'h00);
    push(8'h1C);
    run();
    chk("plain_a_ascii", ascii, 8'h61);
    chk("plain_a_cnt", key_cnt, 8'h03);

    // reset after a lone break prefix
    push(8'hF0);
    run();
    do_reset();
    push(8'h1C);
    run();
    chk("rstmid_kd", 8'(key_down), 8'h01);
    chk("rstmid_cnt", key_cnt, 8'h01);

    // counter wrap over 256 presses
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      case (i % 4)
        0: c = 8'h1C;
        1: c = 8'h32;
        2: c = 8'h21;
        default: c = 8'h23;
      endcase
      push(c);
      push(8'hF0);
      push(c);
      run();
    end
    chk("wrap_cnt", key_cnt, 8'h00);
    chk("wrap_seg4", seg4, 8'h03);
    chk("wrap_seg5", seg5, 8'h03);

    // sticky overflow
    ps2_overflow = 1;
    @(negedge clk);
    ps2_overflow = 0;
    @(negedge clk);
    chk("ovf_set", 8'(ovf_seen), 8'h01);
    chk("ovf_seg0", seg0, 8'hFE);
    repeat (5) @(negedge clk);
    chk("ovf_hold", 8'(ovf_seen), 8'h01);
    do_reset();
    chk("ovf_clr", 8'(ovf_seen), 8'h00);
    chk("ovf_clr_seg0", seg0, 8'hFF);

`ifdef KBD_DECODER_SHIFT_EN
    push(8'h12);
    push(8'h1C);
    run();
    chk("sh_ascii", ascii, 8'h41);
    chk("sh_cnt", key_cnt, 8'h01);
    push(8'hF0);
    push(8'h12);
    run();
    chk("unsh_ascii", ascii, 8'h61);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
